// File: rtl/traveler_cmd_pkg.sv
// ============================================================================
// Module   : traveler_cmd_pkg
// Purpose  : Action codes and IDs for the traveler button command link.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package traveler_cmd_pkg;

    localparam int ID_W = 3;

    localparam logic [7:0] CODE_MOVE     = 8'h06;
    localparam logic [7:0] CODE_THROW    = 8'h0A;
    localparam logic [7:0] CODE_INTERACT = 8'h12;
    localparam logic [7:0] CODE_GET      = 8'h22;
    localparam logic [7:0] CODE_PUT      = 8'h42;

    localparam logic [ID_W-1:0] ID_NONE     = 3'd0;
    localparam logic [ID_W-1:0] ID_MOVE     = 3'd1;
    localparam logic [ID_W-1:0] ID_THROW    = 3'd2;
    localparam logic [ID_W-1:0] ID_INTERACT = 3'd3;
    localparam logic [ID_W-1:0] ID_GET      = 3'd4;
    localparam logic [ID_W-1:0] ID_PUT      = 3'd5;

    typedef struct packed {
        logic            legal;
        logic [ID_W-1:0] id;
    } cmd_decode_t;

    // The five legal codes are exactly the values with [1:0]=10, [7]=0 and
    // [6:2] one-hot, so an exhaustive match is equivalent to the rule.
    function automatic cmd_decode_t decode_code(input logic [7:0] code);
        cmd_decode_t d;
        d.legal = 1'b1;
        d.id    = ID_NONE;
        case (code)
            CODE_MOVE:     d.id = ID_MOVE;
            CODE_THROW:    d.id = ID_THROW;
            CODE_INTERACT: d.id = ID_INTERACT;
            CODE_GET:      d.id = ID_GET;
            CODE_PUT:      d.id = ID_PUT;
            default:       d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_fifo.sv
// ============================================================================
// Module   : cmd_fifo
// Purpose  : Parametric first-word-fall-through FIFO; push accepted when full
//            only if a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign level_o = level_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/traveler_command_receiver.sv
// ============================================================================
// Module   : traveler_command_receiver
// Purpose  : Synchronizes the toggle-marked command word, decodes actions and
//            queues them for a valid/ready consumer with status reporting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module traveler_command_receiver
    import traveler_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [8:0]                    cmd_word,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [ID_W-1:0]               cmd_id,
    output logic [$clog2(FIFO_DEPTH):0]   queue_level,
    output logic                          overflow,
    output logic [CNT_W-1:0]              illegal_cnt,
    input  logic                          clear_status
);

    localparam int WARM_CYC = SYNC_STAGES + 1;
    localparam int WARM_W   = $clog2(WARM_CYC + 1);

    logic [8:0]        sync_q [SYNC_STAGES];
    logic [8:0]        s;
    logic              mark_prev_q;
    logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
    logic              warm_done;
    logic              evt;
    cmd_decode_t       dec;

    logic              evt_q;
    logic              legal_q;
    logic [ID_W-1:0]   id_q;

    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;

    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  illegal_cnt_q, illegal_cnt_d;

    assign s         = sync_q[SYNC_STAGES-1];
    assign warm_done = (warm_cnt_q == WARM_W'(WARM_CYC));
    assign evt       = warm_done && (s[8] != mark_prev_q);
    assign dec       = decode_code(s[7:0]);
    assign warm_cnt_d = warm_done ? warm_cnt_q : warm_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            mark_prev_q <= 1'b0;
            warm_cnt_q  <= '0;
        end else begin
            sync_q[0] <= cmd_word;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            mark_prev_q <= s[8];
            warm_cnt_q  <= warm_cnt_d;
        end
    end

    // Decoded event is registered once so the push lands SYNC_STAGES+1 edges
    // after the toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_q   <= 1'b0;
            legal_q <= 1'b0;
            id_q    <= ID_NONE;
        end else begin
            evt_q   <= evt;
            legal_q <= dec.legal;
            id_q    <= dec.id;
        end
    end

    assign push = evt_q && legal_q;
    assign pop  = cmd_valid && cmd_ready;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ID_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (id_q),
        .pop_i   (pop),
        .rdata_o (cmd_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (queue_level)
    );

    assign cmd_valid = !fifo_empty;

    always_comb begin
        overflow_d    = overflow_q;
        illegal_cnt_d = illegal_cnt_q;
        if (clear_status) begin
            overflow_d    = 1'b0;
            illegal_cnt_d = '0;
        end else begin
            if (push && fifo_full && !pop) overflow_d = 1'b1;
            if (evt_q && !legal_q && (illegal_cnt_q != '1))
                illegal_cnt_d = illegal_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q    <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            overflow_q    <= overflow_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign overflow    = overflow_q;
    assign illegal_cnt = illegal_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_traveler_command_receiver.sv
// ============================================================================
// Module   : tb_traveler_command_receiver
// Purpose  : Directed self-checking bench for traveler_command_receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traveler_command_receiver;

    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 8;
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [8:0]       cmd_word;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_id;
    logic [LVL_W-1:0] queue_level;
    logic             overflow;
    logic [CNT_W-1:0] illegal_cnt;
    logic             clear_status;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    traveler_command_receiver #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_word     (cmd_word),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_id       (cmd_id),
        .queue_level  (queue_level),
        .overflow     (overflow),
        .illegal_cnt  (illegal_cnt),
        .clear_status (clear_status)
    );

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Code settles one cycle before the mark flips; the flip lands just
    // before a rising edge N, so the push is at N+3 and valid after it.
    task automatic send(input logic [7:0] code);
        @(negedge clk) cmd_word[7:0] = code;
        @(negedge clk) cmd_word[8]   = ~cmd_word[8];
    endtask

    task automatic test_reset;
        cmd_word = 9'h106; cmd_ready = 1'b0; clear_status = 1'b0; rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", cmd_valid); end
        n_cmp++; if (queue_level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", queue_level); end
        n_cmp++; if (cmd_id !== 3'd0) begin n_err++; $display("FAIL reset_id: got %0d want 0", cmd_id); end
        cycles(20);
        n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL warmup_valid: got %b want 0", cmd_valid); end
        n_cmp++; if (illegal_cnt !== 8'd0) begin n_err++; $display("FAIL warmup_illegal: got %0d want 0", illegal_cnt); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL warmup_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_single;
        cmd_ready = 1'b1;
        send(8'h0A);
        cycles(3);
        n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL single_early: got %b want 0", cmd_valid); end
        cycles(1);
        n_cmp++; if (cmd_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", cmd_valid); end
        n_cmp++; if (cmd_id !== 3'd2) begin n_err++; $display("FAIL single_id: got %0d want 2", cmd_id); end
        cycles(1);
        n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL single_pulse: got %b want 0", cmd_valid); end
        cycles(2);
        n_cmp++; if (queue_level !== 3'd0) begin n_err++; $display("FAIL empty_ready_level: got %0d want 0", queue_level); end
        n_cmp++; if (cmd_id !== 3'd0) begin n_err++; $display("FAIL empty_id: got %0d want 0", cmd_id); end
        cmd_ready = 1'b0;
    endtask

    task automatic test_queue;
        logic [2:0] exp_ids [4];
        exp_ids = '{3'd1, 3'd3, 3'd4, 3'd5};
        cmd_ready = 1'b0;
        send(8'h06); send(8'h12); send(8'h22); send(8'h42); send(8'h06);
        cycles(5);
        n_cmp++; if (queue_level !== 3'd4) begin n_err++; $display("FAIL queue_level_full: got %0d want 4", queue_level); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL queue_overflow: got %b want 1", overflow); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (cmd_id !== exp_ids[i]) begin n_err++; $display("FAIL queue_pop_id[%0d]: got %0d want %0d", i, cmd_id, exp_ids[i]); end
            cmd_ready = 1'b1;
            cycles(1);
            cmd_ready = 1'b0;
            n_cmp++; if (queue_level !== 3'(3 - i)) begin n_err++; $display("FAIL queue_pop_level[%0d]: got %0d want %0d", i, queue_level, 3 - i); end
        end
        n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL queue_drained: got %b want 0", cmd_valid); end
    endtask

    task automatic test_illegal;
        send(8'h07); send(8'h0E); send(8'h82);
        cycles(5);
        n_cmp++; if (illegal_cnt !== 8'd3) begin n_err++; $display("FAIL illegal_cnt: got %0d want 3", illegal_cnt); end
        n_cmp++; if (queue_level !== 3'd0) begin n_err++; $display("FAIL illegal_nopush: got %0d want 0", queue_level); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow_sticky: got %b want 1", overflow); end
        clear_status = 1'b1;
        cycles(1);
        clear_status = 1'b0;
        n_cmp++; if (illegal_cnt !== 8'd0) begin n_err++; $display("FAIL clear_illegal: got %0d want 0", illegal_cnt); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clear_overflow: got %b want 0", overflow); end
        // Clear coincides with the edge that would count this illegal code.
        send(8'h07);
        cycles(3);
        clear_status = 1'b1;
        cycles(1);
        clear_status = 1'b0;
        cycles(2);
        n_cmp++; if (illegal_cnt !== 8'd0) begin n_err++; $display("FAIL clear_priority: got %0d want 0", illegal_cnt); end
    endtask

    task automatic test_full_pop;
        logic [2:0] exp_ids [4];
        exp_ids = '{3'd3, 3'd4, 3'd1, 3'd5};
        cmd_ready = 1'b0;
        send(8'h0A); send(8'h12); send(8'h22); send(8'h06);
        cycles(5);
        n_cmp++; if (queue_level !== 3'd4) begin n_err++; $display("FAIL fullpop_prefill: got %0d want 4", queue_level); end
        send(8'h42);
        cycles(3);
        cmd_ready = 1'b1;
        cycles(1);
        cmd_ready = 1'b0;
        n_cmp++; if (queue_level !== 3'd4) begin n_err++; $display("FAIL fullpop_level: got %0d want 4", queue_level); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_overflow: got %b want 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (cmd_id !== exp_ids[i]) begin n_err++; $display("FAIL fullpop_id[%0d]: got %0d want %0d", i, cmd_id, exp_ids[i]); end
            cmd_ready = 1'b1;
            cycles(1);
            cmd_ready = 1'b0;
        end
        n_cmp++; if (queue_level !== 3'd0) begin n_err++; $display("FAIL fullpop_drain: got %0d want 0", queue_level); end
    endtask

    task automatic test_reset_mid;
        cmd_ready = 1'b0;
        send(8'h06); send(8'h0A); send(8'h12);
        cycles(5);
        n_cmp++; if (queue_level !== 3'd3) begin n_err++; $display("FAIL mid_prefill: got %0d want 3", queue_level); end
        n_cmp++; if (cmd_valid !== 1'b1) begin n_err++; $display("FAIL mid_valid_pre: got %b want 1", cmd_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_valid: got %b want 0", cmd_valid); end
        n_cmp++; if (queue_level !== 3'd0) begin n_err++; $display("FAIL mid_async_level: got %0d want 0", queue_level); end
        @(negedge clk) rst_n = 1'b1;
        cycles(3);
        send(8'h22);
        cycles(3);
        n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL mid_early: got %b want 0", cmd_valid); end
        cycles(1);
        n_cmp++; if (cmd_valid !== 1'b1) begin n_err++; $display("FAIL mid_event_valid: got %b want 1", cmd_valid); end
        n_cmp++; if (cmd_id !== 3'd4) begin n_err++; $display("FAIL mid_event_id: got %0d want 4", cmd_id); end
        n_cmp++; if (queue_level !== 3'd1) begin n_err++; $display("FAIL mid_event_level: got %0d want 1", queue_level); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_queue;
        test_illegal;
        test_full_pop;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
